// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall/bubble/hold/flush handling,
// a travelling valid bit and saturating bubble/hold/flush event counters.
module pipe_stage_reg #(
   parameter int unsigned      WIDTH      = 32,
   parameter int unsigned      STAGE      = 4,
   parameter int unsigned      STALL_W    = 6,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
   parameter int unsigned      CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   hold_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   typedef enum logic [1:0] {
      EV_NONE,
      EV_BUBBLE,
      EV_HOLD,
      EV_FLUSH
   } event_t;

   logic             s_up;
   logic             s_dn;
   event_t           ev;
   logic [WIDTH-1:0] data_nxt;
   logic             valid_nxt;
   logic [CNT_W-1:0] bubble_nxt;
   logic [CNT_W-1:0] hold_nxt;
   logic [CNT_W-1:0] flush_nxt;
   logic             stall_unused;

   if (STAGE >= STALL_W) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE must be less than STALL_W");
   end

   // The last boundary has no downstream stall bit, so it can never hold.
   if (STAGE + 1 < STALL_W) begin : g_dn
      assign s_dn = stall[STAGE+1];
   end else begin : g_no_dn
      assign s_dn = 1'b0;
   end

   assign s_up         = stall[STAGE];
   assign stall_unused = ^stall;

   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic             hit,
                                                 input logic             clr);
      logic [CNT_W-1:0] nxt;
      nxt = cnt;
      if (clr) begin
         nxt = '0;
      end else if (hit && (cnt != '1)) begin
         nxt = cnt + CNT_W'(1);
      end
      return nxt;
   endfunction

   // Priority: flush, bubble, hold (incl. the illegal downstream-only stall), advance.
   always_comb begin
      ev        = EV_NONE;
      data_nxt  = out_data;
      valid_nxt = out_valid;
      if (flush) begin
         ev        = EV_FLUSH;
         data_nxt  = BUBBLE_VAL;
         valid_nxt = 1'b0;
      end else if (s_up && !s_dn) begin
         ev        = EV_BUBBLE;
         data_nxt  = BUBBLE_VAL;
         valid_nxt = 1'b0;
      end else if (s_dn) begin
         ev = EV_HOLD;
      end else begin
         data_nxt  = in_data;
         valid_nxt = in_valid;
      end
      bubble_nxt = cnt_next(bubble_cnt, ev == EV_BUBBLE, cnt_clr);
      hold_nxt   = cnt_next(hold_cnt,   ev == EV_HOLD,   cnt_clr);
      flush_nxt  = cnt_next(flush_cnt,  ev == EV_FLUSH,  cnt_clr);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_data   <= BUBBLE_VAL;
         out_valid  <= 1'b0;
         bubble_cnt <= '0;
         hold_cnt   <= '0;
         flush_cnt  <= '0;
      end else begin
         out_data   <= data_nxt;
         out_valid  <= valid_nxt;
         bubble_cnt <= bubble_nxt;
         hold_cnt   <= hold_nxt;
         flush_cnt  <= flush_nxt;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (default, 4-bit counters, last stage)
// driven in lockstep and compared every cycle against a behavioural model.
module tb_pipe_stage_reg;

   localparam int unsigned W  = 32;
   localparam int unsigned SW = 6;

   logic          clk;
   logic          rst;
   logic [SW-1:0] stall;
   logic          flush;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          cnt_clr;

   logic [W-1:0]  d0, d1, d2;
   logic          v0, v1, v2;
   logic [15:0]   b0, h0, f0, b2, h2, f2;
   logic [3:0]    b1, h1, f1;

   int checks = 0;
   int passed = 0;

   // Per-instance configuration and model state (counter index 0 bubble, 1 hold, 2 flush).
   int          stg[3] = '{4, 4, 5};
   int          cw[3]  = '{16, 4, 16};
   logic [31:0] m_data[3];
   logic        m_valid[3];
   int          m_cnt[3][3];

   pipe_stage_reg #(.WIDTH(W), .STAGE(4), .STALL_W(SW), .BUBBLE_VAL('0), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_data(in_data),
      .in_valid(in_valid), .out_data(d0), .out_valid(v0), .cnt_clr(cnt_clr),
      .bubble_cnt(b0), .hold_cnt(h0), .flush_cnt(f0));

   pipe_stage_reg #(.WIDTH(W), .STAGE(4), .STALL_W(SW), .BUBBLE_VAL('0), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_data(in_data),
      .in_valid(in_valid), .out_data(d1), .out_valid(v1), .cnt_clr(cnt_clr),
      .bubble_cnt(b1), .hold_cnt(h1), .flush_cnt(f1));

   pipe_stage_reg #(.WIDTH(W), .STAGE(5), .STALL_W(SW), .BUBBLE_VAL('0), .CNT_W(16)) dut_last (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_data(in_data),
      .in_valid(in_valid), .out_data(d2), .out_valid(v2), .cnt_clr(cnt_clr),
      .bubble_cnt(b2), .hold_cnt(h2), .flush_cnt(f2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Reference behaviour: what each boundary register should hold after this edge.
   task automatic model_update();
      for (int k = 0; k < 3; k++) begin
         logic sup, sdn;
         int   ev, mx;
         sup = stall[stg[k]];
         sdn = 1'b0;
         if (stg[k] + 1 < SW) sdn = stall[stg[k]+1];
         mx  = (1 << cw[k]) - 1;
         if (!rst) begin
            m_data[k]  = '0;
            m_valid[k] = 1'b0;
            for (int c = 0; c < 3; c++) m_cnt[k][c] = 0;
         end else begin
            ev = -1;
            if (flush) begin
               ev = 2; m_data[k] = '0; m_valid[k] = 1'b0;
            end else if (sup && !sdn) begin
               ev = 0; m_data[k] = '0; m_valid[k] = 1'b0;
            end else if (sdn) begin
               ev = 1;
            end else begin
               m_data[k] = in_data; m_valid[k] = in_valid;
            end
            if (cnt_clr) begin
               for (int c = 0; c < 3; c++) m_cnt[k][c] = 0;
            end else if (ev >= 0 && m_cnt[k][ev] < mx) begin
               m_cnt[k][ev] = m_cnt[k][ev] + 1;
            end
         end
      end
   endtask

   task automatic chk_inst(input int k, input logic [31:0] d, input logic v,
                           input logic [31:0] b, input logic [31:0] h, input logic [31:0] f);
      chk($sformatf("i%0d out_data", k),   d, m_data[k]);
      chk($sformatf("i%0d out_valid", k),  32'(v), 32'(m_valid[k]));
      chk($sformatf("i%0d bubble_cnt", k), b, 32'(m_cnt[k][0]));
      chk($sformatf("i%0d hold_cnt", k),   h, 32'(m_cnt[k][1]));
      chk($sformatf("i%0d flush_cnt", k),  f, 32'(m_cnt[k][2]));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      chk_inst(0, d0, v0, 32'(b0), 32'(h0), 32'(f0));
      chk_inst(1, d1, v1, 32'(b1), 32'(h1), 32'(f1));
      chk_inst(2, d2, v2, 32'(b2), 32'(h2), 32'(f2));
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         m_data[k] = '0; m_valid[k] = 1'b0;
         for (int c = 0; c < 3; c++) m_cnt[k][c] = 0;
      end
      rst = 1'b0; stall = '0; flush = 1'b0; cnt_clr = 1'b0;
      in_data = 32'hDEADBEEF; in_valid = 1'b1;

      // Reset then advance
      step(); step();
      chk("reset data", d0, 32'h0);
      chk("reset valid", 32'(v0), 32'h0);
      rst = 1'b1;
      step();
      chk("advance data", d0, 32'hDEADBEEF);
      chk("advance valid", 32'(v0), 32'h1);
      chk("advance cnt", 32'(b0) | 32'(h0) | 32'(f0), 32'h0);

      // Bubble from stall[4] alone
      in_data = 32'h12345678; step();
      stall = 6'b010000;
      for (int i = 0; i < 3; i++) step();
      chk("bubble data", d0, 32'h0);
      chk("bubble valid", 32'(v0), 32'h0);
      chk("bubble cnt", 32'(b0), 32'd3);
      chk("bubble hold", 32'(h0), 32'd0);
      chk("last advances", d2, 32'h12345678);

      // Hold with both sides stalled
      stall = '0; in_data = 32'hA5A5A5A5; step();
      stall = 6'b110000;
      for (int i = 0; i < 4; i++) begin
         in_data = (i % 2 == 0) ? 32'h5A5A5A5A : 32'h0F0F0F0F;
         step();
      end
      chk("hold data", d0, 32'hA5A5A5A5);
      chk("hold valid", 32'(v0), 32'h1);
      chk("hold cnt", 32'(h0), 32'd4);
      chk("last bubbles", 32'(v2), 32'h0);
      stall = '0; in_data = 32'h1; step();
      chk("release data", d0, 32'h1);

      // Flush beats hold
      in_data = 32'hCAFEF00D; step();
      stall = 6'b110000; step();
      flush = 1'b1; step();
      flush = 1'b0;
      chk("flush data", d0, 32'h0);
      chk("flush valid", 32'(v0), 32'h0);
      chk("flush cnt", 32'(f0), 32'd1);
      chk("flush no hold", 32'(h0), 32'd5);

      // Saturation of a 4-bit counter, then clear racing an increment
      stall = 6'b010000;
      for (int i = 0; i < 20; i++) step();
      chk("sat bubble", 32'(b1), 32'd15);
      cnt_clr = 1'b1; step();
      chk("clr bubble", 32'(b1), 32'd0);
      cnt_clr = 1'b0; step();
      chk("post clr bubble", 32'(b1), 32'd1);

      // Last-stage boundary never holds; mid-hold reset discards everything
      stall = '0; in_data = 32'h77; step();
      stall = 6'b100000;
      for (int i = 0; i < 3; i++) step();
      chk("last no hold", 32'(h2), 32'd0);
      chk("mid hold data", d0, 32'h77);
      rst = 1'b0; step();
      chk("mid reset data", d0, 32'h0);
      chk("mid reset cnt", 32'(h0), 32'd0);
      rst = 1'b1; stall = '0; in_data = 32'h99; step();
      chk("post reset data", d0, 32'h99);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 49) != 0);
         flush    = ($urandom_range(0, 9) == 0);
         cnt_clr  = ($urandom_range(0, 29) == 0);
         stall    = SW'($urandom);
         if ($urandom_range(0, 1) == 0) stall = '0;
         in_data  = $urandom;
         in_valid = 1'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
